// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache responder.
package icache_pkg;

    localparam int unsigned ADDR_BITS     = 64;
    localparam int unsigned LINE_BYTES    = 64;
    localparam int unsigned LINE_BITS     = LINE_BYTES * 8;
    localparam int unsigned BEATS         = 8;
    localparam int unsigned BEAT_BITS     = 64;
    localparam int unsigned BEAT_IDX_BITS = 3;
    localparam int unsigned OFFSET_BITS   = 6;
    localparam int unsigned DEFAULT_SETS  = 64;

    typedef logic [LINE_BITS-1:0] line_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        FILL,
        RESPOND
    } ic_state_t;

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data store: one fill write port, one combinational
// lookup read port and a bulk valid clear.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned SETS = DEFAULT_SETS,
    localparam int unsigned IDX_BITS = $clog2(SETS),
    localparam int unsigned TAG_BITS = ADDR_BITS - OFFSET_BITS - IDX_BITS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0] wr_tag,
    input  logic                wr_valid,
    input  line_t               wr_data,
    input  logic [IDX_BITS-1:0] rd_index,
    output logic [TAG_BITS-1:0] rd_tag_c,
    output logic                rd_valid_c,
    output line_t               rd_data_c
);

    logic [SETS-1:0]     valid;
    logic [TAG_BITS-1:0] tags  [SETS];
    line_t               lines [SETS];

    // Clear wins over a same-edge fill; the fill then carries wr_valid=0 anyway.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (clear) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_index] <= wr_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_index]  <= wr_tag;
            lines[wr_index] <= wr_data;
        end
    end

    assign rd_tag_c   = tags[rd_index];
    assign rd_valid_c = valid[rd_index];
    assign rd_data_c  = lines[rd_index];

endmodule

// File: rtl/icache_responder.sv
// Fetch-side instruction-cache responder with 8-beat line fill from memory.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_responder
    import icache_pkg::*;
#(
    parameter int unsigned SETS = DEFAULT_SETS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ic_enable,
    input  logic [ADDR_BITS-1:0] iaddr,
    output line_t                idata,
    output logic                 ic_done,
    input  logic                 invalidate,
    output logic                 mem_reqcyc,
    output logic [ADDR_BITS-1:0] mem_req,
    input  logic                 mem_reqack,
    input  logic                 mem_respcyc,
    input  logic [BEAT_BITS-1:0] mem_resp,
`ifdef ICACHE_STATS_EN
    output logic [31:0]          hit_count,
    output logic [31:0]          miss_count,
`endif
    output logic                 mem_respack
);

    localparam int unsigned IDX_BITS = $clog2(SETS);
    localparam int unsigned TAG_BITS = ADDR_BITS - OFFSET_BITS - IDX_BITS;

    ic_state_t              state, state_next;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [BEAT_IDX_BITS-1:0] beat_cnt;
    line_t                  fill_line;
    logic                   inval_pend;

    logic [TAG_BITS-1:0]    rd_tag_c;
    logic                   rd_valid_c;
    line_t                  rd_data_c;
    logic                   hit_c;
    logic                   fill_last_c;
    line_t                  fill_data_c;
    logic                   arr_wr_en_c;

    logic                   ic_done_d;
    line_t                  idata_d;
    logic                   mem_reqcyc_d;
    logic [ADDR_BITS-1:0]   mem_req_d;

    icache_array #(.SETS(SETS)) u_array (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (invalidate),
        .wr_en      (arr_wr_en_c),
        .wr_index   (req_addr[OFFSET_BITS +: IDX_BITS]),
        .wr_tag     (req_addr[ADDR_BITS-1 -: TAG_BITS]),
        .wr_valid   (!(inval_pend || invalidate)),
        .wr_data    (fill_data_c),
        .rd_index   (req_addr[OFFSET_BITS +: IDX_BITS]),
        .rd_tag_c   (rd_tag_c),
        .rd_valid_c (rd_valid_c),
        .rd_data_c  (rd_data_c)
    );

    // A flush landing on the lookup cycle forces a miss.
    assign hit_c       = rd_valid_c && (rd_tag_c == req_addr[ADDR_BITS-1 -: TAG_BITS]) && !invalidate;
    assign fill_last_c = (state == FILL) && mem_respcyc && (beat_cnt == BEAT_IDX_BITS'(BEATS - 1));
    assign fill_data_c = {mem_resp, fill_line[LINE_BITS-BEAT_BITS-1:0]};

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ic_done    <= 1'b0;
            idata      <= '0;
            mem_reqcyc <= 1'b0;
            mem_req    <= '0;
        end else begin
            state      <= state_next;
            ic_done    <= ic_done_d;
            idata      <= idata_d;
            mem_reqcyc <= mem_reqcyc_d;
            mem_req    <= mem_req_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (ic_enable) state_next = LOOKUP;
            LOOKUP:   state_next = hit_c ? RESPOND : MISS_REQ;
            MISS_REQ: if (mem_reqack) state_next = FILL;
            FILL:     if (fill_last_c) state_next = RESPOND;
            RESPOND:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        ic_done_d    = 1'b0;
        idata_d      = idata;
        mem_reqcyc_d = 1'b0;
        mem_req_d    = mem_req;
        mem_respack  = 1'b0;
        arr_wr_en_c  = 1'b0;
        case (state)
            LOOKUP: begin
                if (hit_c) begin
                    ic_done_d = 1'b1;
                    idata_d   = rd_data_c;
                end else begin
                    mem_reqcyc_d = 1'b1;
                    mem_req_d    = req_addr;
                end
            end
            MISS_REQ: mem_reqcyc_d = !mem_reqack;
            FILL: begin
                mem_respack = mem_respcyc;
                if (fill_last_c) begin
                    ic_done_d   = 1'b1;
                    idata_d     = fill_data_c;
                    arr_wr_en_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Request latch, beat assembly and the flush-during-miss marker.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_addr   <= '0;
            beat_cnt   <= '0;
            fill_line  <= '0;
            inval_pend <= 1'b0;
        end else begin
            if (state == IDLE && ic_enable) begin
                req_addr <= iaddr & ~ADDR_BITS'(LINE_BYTES - 1);
            end
            if (state == FILL && mem_respcyc) begin
                fill_line[{beat_cnt, 6'b0} +: BEAT_BITS] <= mem_resp;
                beat_cnt <= beat_cnt + BEAT_IDX_BITS'(1);
            end
            inval_pend <= invalidate || (inval_pend && state != IDLE);
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == LOOKUP) begin
            if (hit_c) hit_count  <= hit_count + 32'd1;
            else       miss_count <= miss_count + 32'd1;
        end
    end
`endif

    beat_only_in_fill: assert property (
        @(posedge clk) disable iff (!reset_n) mem_respcyc |-> (state == FILL)
    );

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: vector table plus line scoreboard.
module tb_icache_responder;
    import icache_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        ic_enable;
    logic [63:0] iaddr;
    line_t       idata;
    logic        ic_done;
    logic        invalidate;
    logic        mem_reqcyc;
    logic [63:0] mem_req;
    logic        mem_reqack;
    logic        mem_respcyc;
    logic [63:0] mem_resp;
    logic        mem_respack;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ic_enable   (ic_enable),
        .iaddr       (iaddr),
        .idata       (idata),
        .ic_done     (ic_done),
        .invalidate  (invalidate),
        .mem_reqcyc  (mem_reqcyc),
        .mem_req     (mem_req),
        .mem_reqack  (mem_reqack),
        .mem_respcyc (mem_respcyc),
        .mem_resp    (mem_resp),
`ifdef ICACHE_STATS_EN
        .hit_count   (hit_count),
        .miss_count  (miss_count),
`endif
        .mem_respack (mem_respack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        bit          exp_hit;
        int          ack_dly;
        bit          pre_inval;
        bit          inval_lookup;
        int          inval_beat;
        int          rst_beat;
    } vec_t;

    int    total = 0;
    int    bad = 0;
    int    done_cnt = 0;
    line_t sb[$];
    line_t held = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_line(input string name, input line_t act, input line_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Memory image: line 0x1000 carries 0x11..0x88, others are address-tagged.
    function automatic logic [63:0] beat_val(input logic [63:0] la, input int k);
        if (la == 64'h1000) return 64'(k + 1) * 64'h11;
        return {la[31:0], 32'hC0DE_0000 | 32'(k)};
    endfunction

    function automatic line_t line_val(input logic [63:0] la);
        line_t l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_val(la, k);
        return l;
    endfunction

    // Scoreboard consumer and idata-hold check.
    always @(negedge clk) begin
        if (reset_n && ic_done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got ic_done=1 want no response");
            end else begin
                line_t e;
                e = sb.pop_front();
                chk_line("idata", idata, e);
                held = e;
            end
        end else if (reset_n) begin
            chk_line("idata_hold", idata, held);
        end
    end

    task automatic run_req(input vec_t v);
        logic [63:0] la;
        int          d0;
        la = v.addr & ~64'h3f;
        d0 = done_cnt;
        if (v.pre_inval) begin
            invalidate = 1'b1;
            @(negedge clk);
            invalidate = 1'b0;
        end
        ic_enable = 1'b1;
        iaddr     = v.addr;
        @(negedge clk);
        ic_enable = 1'b0;
        iaddr     = {$urandom, $urandom};
        chk("lookup_done", 64'(ic_done), 64'd0);
        chk("lookup_reqcyc", 64'(mem_reqcyc), 64'd0);
        if (v.rst_beat < 0) sb.push_back(line_val(la));
        invalidate = v.inval_lookup;
        @(negedge clk);
        invalidate = 1'b0;
        if (v.exp_hit) begin
            chk("hit_reqcyc", 64'(mem_reqcyc), 64'd0);
            chk("hit_done", 64'(ic_done), 64'd1);
        end else begin
            chk("miss_reqcyc", 64'(mem_reqcyc), 64'd1);
            chk("miss_req", mem_req, la);
            chk("miss_done", 64'(ic_done), 64'd0);
            for (int i = 1; i < v.ack_dly; i++) begin
                @(negedge clk);
                chk("reqcyc_held", 64'(mem_reqcyc), 64'd1);
            end
            mem_reqack = 1'b1;
            @(negedge clk);
            mem_reqack = 1'b0;
            chk("reqcyc_drop", 64'(mem_reqcyc), 64'd0);
            for (int k = 0; k < 8; k++) begin
                if (k == v.rst_beat) begin
                    reset_n     = 1'b0;
                    mem_respcyc = 1'b0;
                    @(negedge clk);
                    chk("rst_done", 64'(ic_done), 64'd0);
                    chk_line("rst_idata", idata, '0);
                    chk("rst_reqcyc", 64'(mem_reqcyc), 64'd0);
                    chk("rst_req", mem_req, 64'd0);
                    held    = '0;
                    reset_n = 1'b1;
                    repeat (10) @(negedge clk);
                    chk("rst_no_done", 64'(done_cnt), 64'(d0));
                    return;
                end
                mem_respcyc = 1'b1;
                mem_resp    = beat_val(la, k);
                invalidate  = (k == v.inval_beat);
                #1;
                if (k == 0) chk("respack", 64'(mem_respack), 64'd1);
                @(negedge clk);
            end
            mem_respcyc = 1'b0;
            invalidate  = 1'b0;
            chk("fill_done", 64'(ic_done), 64'd1);
        end
        @(negedge clk);
        chk("done_pulse", 64'(ic_done), 64'd0);
        chk("done_once", 64'(done_cnt), 64'(d0 + 1));
    endtask

    vec_t vecs[16];
    int   exp_dones;

    initial begin
        vecs[0]  = '{64'h1000, 1'b0, 2, 1'b0, 1'b0, -1, -1};
        vecs[1]  = '{64'h1010, 1'b1, 0, 1'b0, 1'b0, -1, -1};
        vecs[2]  = '{64'h1000, 1'b0, 3, 1'b1, 1'b0, -1, -1};
        vecs[3]  = '{64'h2000, 1'b0, 2, 1'b0, 1'b0, -1, -1};
        vecs[4]  = '{64'h1000, 1'b0, 1, 1'b0, 1'b0, -1, -1};
        vecs[5]  = '{64'h3000, 1'b0, 2, 1'b0, 1'b0,  4, -1};
        vecs[6]  = '{64'h3000, 1'b0, 1, 1'b0, 1'b0, -1, -1};
        vecs[7]  = '{64'h3000, 1'b1, 0, 1'b0, 1'b0, -1, -1};
        vecs[8]  = '{64'h5040, 1'b0, 1, 1'b0, 1'b0, -1, -1};
        vecs[9]  = '{64'h5040, 1'b0, 2, 1'b0, 1'b1, -1, -1};
        vecs[10] = '{64'h5040, 1'b0, 1, 1'b0, 1'b0, -1, -1};
        vecs[11] = '{64'h5040, 1'b1, 0, 1'b0, 1'b0, -1, -1};
        vecs[12] = '{64'h4000, 1'b0, 2, 1'b0, 1'b0, -1,  3};
        vecs[13] = '{64'h4000, 1'b0, 2, 1'b0, 1'b0, -1, -1};
        vecs[14] = '{64'h5040, 1'b0, 1, 1'b0, 1'b0, -1, -1};
        vecs[15] = '{64'h4020, 1'b1, 0, 1'b0, 1'b0, -1, -1};

        reset_n     = 1'b0;
        ic_enable   = 1'b0;
        iaddr       = '0;
        invalidate  = 1'b0;
        mem_reqack  = 1'b0;
        mem_respcyc = 1'b0;
        mem_resp    = '0;
        repeat (2) @(negedge clk);
        chk("reset_done", 64'(ic_done), 64'd0);
        chk_line("reset_idata", idata, '0);
        chk("reset_reqcyc", 64'(mem_reqcyc), 64'd0);
        chk("reset_req", mem_req, 64'd0);
        chk("reset_respack", 64'(mem_respack), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        exp_dones = 0;
        for (int i = 0; i < 16; i++) begin
            run_req(vecs[i]);
            if (vecs[i].rst_beat < 0) exp_dones++;
            if (i == 0) begin
                chk("t1_beat0", idata[63:0], 64'h11);
                chk("t1_beat7", idata[511:448], 64'h88);
            end
`ifdef ICACHE_STATS_EN
            if (i == 4) begin
                chk("hit_count", 64'(hit_count), 64'd1);
                chk("miss_count", 64'(miss_count), 64'd4);
            end
`endif
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("done_total", 64'(done_cnt), 64'(exp_dones));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
